bram_delay_chain: RTL and testbench

//  Parametrised heater/self-test delay chain. CHANNELS independent LFSR streams,

---
 rtl/bram_delay_chain.sv | 196 +++++++++++++++++++
 tb/tb_bram_delay_chain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_delay_chain.sv
// bram_delay_chain: per-channel LFSR sources pushed through cascaded
// circular-buffer block RAM delays and output flops, then compared against a
// replica generator that starts once the pipeline holds only fresh data.
module bram_delay_chain #(
    parameter int          WIDTH    = 32,
    parameter int          CHANNELS = 4,
    parameter int          STAGES   = 4,
    parameter int          DEPTH    = 1024,
    parameter int          OUT_REGS = 2,
    parameter logic [31:0] SEED     = 32'h1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                restart,
    input  logic [CHANNELS-1:0] inject_err,
    input  logic                err_clear,
    output logic                locked,
    output logic [CHANNELS-1:0] error,
    output logic [15:0]         err_count
);
    localparam int          PTR_W     = $clog2(DEPTH);
    localparam int          LATENCY   = STAGES * DEPTH + OUT_REGS;
    localparam logic [31:0] FILL_LAST = 32'(LATENCY - 1);
    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [31:0]         fill_cnt_q, fill_cnt_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    rd_addr;
    logic [CHANNELS-1:0] error_q, error_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [CHANNELS-1:0] mism;
    logic [15:0]         n_mism;
    logic [15:0]         err_base;
    logic [16:0]         err_sum;
    logic                adv_src;
    logic                check_en;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // LFSR state tiled across the word, channel number folded into the low bits
    function automatic logic [WIDTH-1:0] make_word(input logic [31:0] s, input int ch);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = s[5'(i % 32)];
        end
        return w ^ WIDTH'(ch);
    endfunction

    // Sources run from the first FILL step; the checker and its replicas only in RUN.
    // A restart cycle neither advances nor checks, so any inject on it is dropped.
    assign adv_src  = enable && !restart && (state_q != S_IDLE);
    assign check_en = enable && !restart && (state_q == S_RUN);
    assign locked   = (state_q == S_RUN);
    assign error    = error_q;
    assign err_count = err_count_q;

    // The read register adds one step, so each stage reads the slot written
    // DEPTH-1 steps ago; with the register the stage delay is exactly DEPTH.
    assign rd_addr = ptr_q + PTR_W'(1);

    // FSM next state: restart wins over everything, otherwise advance on steps only
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (restart) begin
            state_d    = S_FILL;
            fill_cnt_d = '0;
        end else if (enable) begin
            case (state_q)
                S_IDLE: state_d = S_FILL;
                S_FILL: begin
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 32'd1;
                    end
                end
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Count mismatching channels this step
    always_comb begin
        n_mism = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            n_mism = n_mism + 16'(mism[c]);
        end
    end

    // Sticky flags and saturating counter; a same-cycle mismatch survives err_clear
    always_comb begin
        err_base    = err_clear ? 16'd0 : err_count_q;
        error_d     = (err_clear ? '0 : error_q) | mism;
        err_sum     = {1'b0, err_base} + {1'b0, n_mism};
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Control state, shared pointer and error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            ptr_q       <= '0;
            error_q     <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            ptr_q       <= enable ? (ptr_q + PTR_W'(1)) : ptr_q;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    genvar gi, gs;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [31:0]      src_q, src_d;
            logic [31:0]      ref_q, ref_d;
            logic [WIDTH-1:0] stage_in [STAGES+1];
            logic [WIDTH-1:0] chk_word;
            logic             inj_bit;

            assign inj_bit     = inject_err[gi] && adv_src;
            assign stage_in[0] = make_word(src_q, gi) ^ {{(WIDTH-1){1'b0}}, inj_bit};

            // Source and replica next state: reseed on restart, otherwise step
            always_comb begin
                src_d = src_q;
                ref_d = ref_q;
                if (restart) begin
                    src_d = SEED + 32'(gi);
                    ref_d = SEED + 32'(gi);
                end else begin
                    if (adv_src)  src_d = lfsr_next(src_q);
                    if (check_en) ref_d = lfsr_next(ref_q);
                end
            end

            // Source and replica LFSR registers
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    src_q <= SEED + 32'(gi);
                    ref_q <= SEED + 32'(gi);
                end else begin
                    src_q <= src_d;
                    ref_q <= ref_d;
                end
            end

            for (gs = 0; gs < STAGES; gs++) begin : g_stage
                logic [WIDTH-1:0] mem [DEPTH];
                logic [WIDTH-1:0] rd_q;

                // Circular buffer: write the incoming word, register the oldest one
                always_ff @(posedge clk) begin
                    if (enable) begin
                        mem[ptr_q] <= stage_in[gs];
                        rd_q       <= mem[rd_addr];
                    end
                end

                assign stage_in[gs+1] = rd_q;
            end

            if (OUT_REGS > 0) begin : g_out
                logic [WIDTH-1:0] out_q [OUT_REGS];

                // Output pipeline after the last block RAM
                always_ff @(posedge clk) begin
                    if (enable) begin
                        out_q[0] <= stage_in[STAGES];
                        for (int k = 1; k < OUT_REGS; k++) begin
                            out_q[k] <= out_q[k-1];
                        end
                    end
                end

                assign chk_word = out_q[OUT_REGS-1];
            end else begin : g_no_out
                assign chk_word = stage_in[STAGES];
            end

            assign mism[gi] = check_en && (chk_word != make_word(ref_q, gi));
        end
    endgenerate

endmodule

// File: tb/tb_bram_delay_chain.sv
// Directed bench for bram_delay_chain: a default-size instance plus two small
// instances (48-bit single channel, and an 8-channel one for counter saturation).
`timescale 1ns/1ps
module tb_bram_delay_chain;
    localparam int LAT_A = 4 * 1024 + 2;
    localparam int LAT_B = 4;
    localparam int LAT_C = 1 * 4 + 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        en_a, rs_a, clr_a, lock_a;
    logic [3:0]  inj_a, err_a;
    logic [15:0] cnt_a;
    logic        en_b, rs_b, clr_b, lock_b;
    logic [0:0]  inj_b, err_b;
    logic [15:0] cnt_b;
    logic        en_c, rs_c, clr_c, lock_c;
    logic [7:0]  inj_c, err_c;
    logic [15:0] cnt_c;

    bram_delay_chain dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .restart(rs_a),
        .inject_err(inj_a), .err_clear(clr_a),
        .locked(lock_a), .error(err_a), .err_count(cnt_a)
    );

    bram_delay_chain #(.WIDTH(48), .CHANNELS(1), .STAGES(1), .DEPTH(4), .OUT_REGS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .restart(rs_b),
        .inject_err(inj_b), .err_clear(clr_b),
        .locked(lock_b), .error(err_b), .err_count(cnt_b)
    );

    bram_delay_chain #(.WIDTH(16), .CHANNELS(8), .STAGES(1), .DEPTH(4), .OUT_REGS(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .enable(en_c), .restart(rs_c),
        .inject_err(inj_c), .err_clear(clr_c),
        .locked(lock_c), .error(err_c), .err_count(cnt_c)
    );

    typedef struct {
        int          dut;
        int          due;
        logic [7:0]  err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   steps_a = 0, steps_b = 0, steps_c = 0;
    int   n, cyc;
    logic [15:0] model_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; count steps per instance and retire any scoreboard entry now due
    task automatic tick();
        logic        hit;
        logic [7:0]  oe;
        logic [15:0] oc;
        @(posedge clk);
        #1;
        if (en_a) steps_a++;
        if (en_b) steps_b++;
        if (en_c) steps_c++;
        while (sb.size() > 0) begin
            hit = 1'b0;
            oe  = '0;
            oc  = '0;
            if (sb[0].dut == 0 && sb[0].due == steps_a) begin
                hit = 1'b1; oe = {4'b0, err_a}; oc = cnt_a;
            end else if (sb[0].dut == 1 && sb[0].due == steps_b) begin
                hit = 1'b1; oe = {7'b0, err_b}; oc = cnt_b;
            end else if (sb[0].dut == 2 && sb[0].due == steps_c) begin
                hit = 1'b1; oe = err_c; oc = cnt_c;
            end
            if (!hit) break;
            $display("txn dut=%0d step=%0d error=%0h err_count=%0d", sb[0].dut, sb[0].due, oe, oc);
            chk("sb_error", 32'(oe), 32'(sb[0].err));
            chk("sb_count", 32'(oc), 32'(sb[0].cnt));
            void'(sb.pop_front());
        end
    endtask

    // Inject on one step of instance A; the corrupted word is checked LATENCY steps later
    task automatic inject_a(input logic [3:0] mask, input logic [3:0] e_err, input logic [15:0] e_cnt);
        sb.push_back('{0, steps_a + 1 + LAT_A, {4'b0, e_err}, e_cnt});
        inj_a = mask;
        tick();
        inj_a = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        en_a = 0; rs_a = 0; clr_a = 0; inj_a = '0;
        en_b = 0; rs_b = 0; clr_b = 0; inj_b = '0;
        en_c = 0; rs_c = 0; clr_c = 0; inj_c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(lock_a), 32'd0);
        chk("rst_error", 32'(err_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_no_enable", 32'(lock_a), 32'd0);

        // T1: first step leaves IDLE, locked follows LATENCY steps later
        en_a = 1'b1;
        n = 0;
        while (!lock_a && n < LAT_A + 50) begin
            tick();
            n++;
        end
        $display("txn t1 lock after %0d steps", n);
        chk("t1_lock_steps", 32'(n), 32'(LAT_A + 1));
        repeat (2000) tick();
        chk("t1_locked", 32'(lock_a), 32'd1);
        chk("t1_error", 32'(err_a), 32'd0);
        chk("t1_count", 32'(cnt_a), 32'd0);

        // T2: single-channel inject surfaces once, exactly LATENCY steps later
        inject_a(4'b0100, 4'b0100, 16'd1);
        repeat (LAT_A - 1) tick();
        chk("t2_before_due", 32'(cnt_a), 32'd0);
        tick();
        repeat (200) tick();
        chk("t2_no_more", 32'(cnt_a), 32'd1);
        chk("t2_error_hold", 32'(err_a), 32'b0100);

        // T4: all channels at once, err_clear on the mismatch cycle
        inject_a(4'b1111, 4'b1111, 16'd4);
        repeat (LAT_A - 1) tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;

        // T5: restart (with a dropped inject) mid-RUN; errors are kept
        rs_a = 1'b1;
        inj_a = 4'b0001;
        tick();
        rs_a = 1'b0;
        inj_a = '0;
        chk("t5_unlocked", 32'(lock_a), 32'd0);
        chk("t5_error_kept", 32'(err_a), 32'hF);
        chk("t5_count_kept", 32'(cnt_a), 32'd4);
        n = 0;
        while (!lock_a && n < LAT_A + 50) begin
            tick();
            n++;
        end
        $display("txn t5 relock after %0d steps", n);
        chk("t5_relock_steps", 32'(n), 32'(LAT_A));
        repeat (50) tick();
        chk("t5_no_new_err", 32'(cnt_a), 32'd4);

        // Reset in the middle of FILL clears outputs without waiting for a clock
        rs_a = 1'b1;
        tick();
        rs_a = 1'b0;
        repeat (100) tick();
        en_a = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_locked", 32'(lock_a), 32'd0);
        chk("t5_rst_error", 32'(err_a), 32'd0);
        chk("t5_rst_count", 32'(cnt_a), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // T3: random enable; only enabled cycles count as steps
        n = 0;
        cyc = 0;
        while (!lock_a && cyc < 20000) begin
            en_a = 1'($urandom_range(0, 1));
            tick();
            if (en_a) n++;
            cyc++;
        end
        $display("txn t3 lock after %0d steps in %0d cycles", n, cyc);
        chk("t3_lock_steps", 32'(n), 32'(LAT_A + 1));
        repeat (1000) begin
            en_a = 1'($urandom_range(0, 1));
            tick();
        end
        // Inject while frozen is ignored
        en_a = 1'b0;
        inj_a = 4'b1000;
        tick();
        inj_a = '0;
        en_a = 1'b1;
        repeat (LAT_A + 5) tick();
        chk("t3_error", 32'(err_a), 32'd0);
        chk("t3_count", 32'(cnt_a), 32'd0);
        en_a = 1'b0;

        // T6: small 48-bit single-channel chain
        en_b = 1'b1;
        n = 0;
        while (!lock_b && n < 20) begin
            tick();
            n++;
        end
        chk("t6_lock_steps", 32'(n), 32'(LAT_B + 1));
        sb.push_back('{1, steps_b + 1 + LAT_B, 8'h01, 16'd1});
        inj_b = 1'b1;
        tick();
        inj_b = 1'b0;
        repeat (LAT_B - 1) tick();
        chk("t6_before_due", 32'(err_b), 32'd0);
        tick();
        repeat (10) tick();
        chk("t6_count", 32'(cnt_b), 32'd1);
        en_b = 1'b0;

        // Saturation: inject every channel on every step of an 8-channel chain
        en_c = 1'b1;
        n = 0;
        while (!lock_c && n < 20) begin
            tick();
            n++;
        end
        chk("sat_lock_steps", 32'(n), 32'(LAT_C + 1));
        model_cnt = '0;
        for (int k = 0; k < 8250; k++) begin
            model_cnt = (model_cnt > 16'hFFF7) ? 16'hFFFF : model_cnt + 16'd8;
            sb.push_back('{2, steps_c + 1 + LAT_C, 8'hFF, model_cnt});
            inj_c = 8'hFF;
            tick();
        end
        inj_c = '0;
        repeat (LAT_C + 5) tick();
        chk("sat_count", 32'(cnt_c), 32'hFFFF);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
